// File: rtl/msrv32_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_lsu_ctrl
// Brief    : Stage-3 load/store controller. Issues valid/ready data-memory
//            requests, formats store lanes and extends load results.
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_lsu_ctrl (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [31:0] addr_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] rs2_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wmask_out,
    input  logic        dmem_ready_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        mem_done_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        req_q;
    logic        done_q;
    logic        mis_q;
    logic [31:0] load_data_q;

    logic        w_start;
    logic        w_misaligned;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [3:0]  w_wmask;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;

    // Decode of the incoming operation: alignment and store lane formatting.
    always_comb begin
        w_start      = load_in | store_in;
        w_we         = store_in & ~load_in;
        w_misaligned = ((load_size_in == 2'b01) & addr_in[0]) |
                       (load_size_in[1] & (addr_in[1:0] != 2'b00));
        case (load_size_in)
            2'b00: begin
                w_wdata = {4{rs2_in[7:0]}};
                w_wmask = 4'b0001 << addr_in[1:0];
            end
            2'b01: begin
                w_wdata = {2{rs2_in[15:0]}};
                w_wmask = 4'b0011 << addr_in[1:0];
            end
            default: begin
                w_wdata = rs2_in;
                w_wmask = 4'b1111;
            end
        endcase
        if (!w_we) begin
            w_wmask = 4'b0000;
        end
    end

    // Load extraction uses the latched address/size, not the live inputs.
    always_comb begin
        w_shifted = dmem_rdata_in >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   w_load_ext = uns_q ? {24'd0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_ext = uns_q ? {16'd0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = w_misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_ready_in) begin
                    state_d = we_q ? S_DONE : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (dmem_rvalid_in) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'd0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == S_REQ);
            done_q  <= (state_d == S_DONE);
            // Only the IDLE path can reach DONE with a misaligned access.
            mis_q   <= (state_q == S_IDLE) & w_start & w_misaligned;
            if ((state_q == S_IDLE) && w_start && !w_misaligned) begin
                addr_q  <= addr_in;
                size_q  <= load_size_in;
                uns_q   <= load_unsigned_in;
                we_q    <= w_we;
                wdata_q <= w_wdata;
                wmask_q <= w_wmask;
            end
            if ((state_q == S_WAIT_RD) && dmem_rvalid_in) begin
                load_data_q <= w_load_ext;
            end
        end
    end

    assign dmem_req_out   = req_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = {addr_q[31:2], 2'b00};
    assign dmem_wdata_out = wdata_q;
    assign dmem_wmask_out = wmask_q;
    assign mem_done_out   = done_q;
    assign misaligned_out = mis_q;
    assign load_data_out  = load_data_q;
    // Combinational so the pipeline freezes in the cycle the operation appears.
    assign stall_out      = ((state_q == S_IDLE) & w_start) |
                            (state_q == S_REQ) | (state_q == S_WAIT_RD);

endmodule
`default_nettype wire
